// File: rtl/camera_matrix_gen_pkg.sv
// camera_matrix_gen_pkg: shared FP32 constants, mat4 types, FSM states and truncating FP32 helpers
package camera_matrix_gen_pkg;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] ORTHO_X = 32'h3F00_0000;
  localparam logic [31:0] ORTHO_Y = 32'h3F2A_AAAA;
  localparam logic [31:0] ORTHO_Z = 32'hBE80_0000;
  localparam logic [31:0] ORTHO_W = 32'hBF80_0000;
  typedef logic [3:0][31:0] vec4_t;
  typedef vec4_t [3:0] mat4_t;
  typedef enum logic [1:0] {ST_IDLE, ST_VIEW, ST_PROJ, ST_OUT} state_e;

  function automatic logic [31:0] fp_neg(input logic [31:0] a);
    return {~a[31], a[30:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [22:0] f;
    int e;
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127 + int'(m[47]);
    f = m[47] ? m[46:24] : m[45:23];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0) return {a[31] ^ b[31], 31'd0};
    if (e >= 255) return {a[31] ^ b[31], 8'hFF, 23'd0};
    return {a[31] ^ b[31], e[7:0], f};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [26:0] mx, my, s;
    int d, p, e;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    {x, y} = (a[30:0] < b[30:0]) ? {b, a} : {a, b};
    d = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0], 2'b00};
    my = (d > 26) ? 27'd0 : ({2'b01, y[22:0], 2'b00} >> d);
    s = (x[31] == y[31]) ? mx + my : mx - my;
    p = -1;
    for (int i = 0; i < 27; i++) if (s[i]) p = i;
    if (p < 0) return FP_ZERO;
    e = int'(x[30:23]) + p - 25;
    s = s << (26 - p);
    if (e <= 0) return {x[31], 31'd0};
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], s[25:3]};
  endfunction

  function automatic mat4_t proj_reset(input int s);
    mat4_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = FP_ONE;
    if (s == 0) begin
      m[0][0] = ORTHO_X;
      m[1][1] = ORTHO_Y;
      m[2][2] = ORTHO_Z;
      m[2][3] = ORTHO_W;
    end
    return m;
  endfunction
endpackage

// File: rtl/camera_matrix_gen_fp32_dot.sv
// fp32_dot: two-stage pipelined FP32 4-element dot product, in-order results
module fp32_dot
  import camera_matrix_gen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [3:0][31:0] a_in,
  input  logic [3:0][31:0] b_in,
  output logic             valid_out,
  output logic [31:0]      c_out
);
  vec4_t prod;
  logic  prod_v;
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_v    <= 1'b0;
      valid_out <= 1'b0;
      prod      <= '0;
      c_out     <= '0;
    end else begin
      prod_v    <= valid_in;
      valid_out <= prod_v;
      for (int k = 0; k < 4; k++) prod[k] <= fp_mul(a_in[k], b_in[k]);
      c_out <= fp_add(fp_add(prod[0], prod[1]), fp_add(prod[2], prod[3]));
    end
  end
endmodule

// File: rtl/camera_matrix_gen.sv
// camera_matrix_gen: builds R = P[slot] * (B * T) with one shared dot unit, streams R column by column
module camera_matrix_gen
  import camera_matrix_gen_pkg::*;
#(
  parameter int NUM_PROJ = 4,
  parameter int SLOT_W   = $clog2(NUM_PROJ)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [2:0][31:0]  right_in,
  input  logic [2:0][31:0]  up_in,
  input  logic [2:0][31:0]  direction_in,
  input  logic [2:0][31:0]  pos_in,
  input  logic [SLOT_W-1:0] proj_sel_in,
  input  logic              skip_proj_in,
  input  logic              proj_wr_en_in,
  input  logic [SLOT_W-1:0] proj_wr_slot_in,
  input  logic [1:0]        proj_wr_row_in,
  input  logic [3:0][31:0]  proj_wr_data_in,
  output logic              proj_wr_err_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [3:0][31:0]  col_out,
  output logic [1:0]        col_idx_out
);
  state_e state, state_nx;
  logic [2:0][2:0][31:0] basis;
  logic [2:0][31:0] pos;
  mat4_t proj [NUM_PROJ];
  mat4_t v_m, r_m;
  logic [SLOT_W-1:0] sel;
  logic skip, accept, wr_ok, dot_v_in, dot_v, collect, last;
  logic [4:0] iss_cnt;
  logic [3:0] col_cnt;
  logic [1:0] out_idx, op_i, op_j;
  logic [31:0] dot_c;
  vec4_t op_a, op_b, b_row, t_col;

  assign accept  = valid_in && ready_out;
  assign wr_ok   = proj_wr_en_in && state == ST_IDLE && int'(proj_wr_slot_in) < NUM_PROJ;
  assign collect = dot_v && (state == ST_VIEW || state == ST_PROJ);
  assign last    = collect && col_cnt == 4'd15;

  always_comb begin
    state_nx    = state;
    ready_out   = state == ST_IDLE;
    valid_out   = state == ST_OUT;
    col_idx_out = out_idx;
    col_out     = valid_out ? (skip ? v_m[out_idx] : r_m[out_idx]) : '0;
    dot_v_in    = (state == ST_VIEW || state == ST_PROJ) && !iss_cnt[4];
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_VIEW;
      ST_VIEW: if (last) state_nx = skip ? ST_OUT : ST_PROJ;
      ST_PROJ: if (last) state_nx = ST_OUT;
      default: if (ready_in && out_idx == 2'd3) state_nx = ST_IDLE;
    endcase
  end

  // operands for element (i,j): row i of B or P, column j of T or V
  always_comb begin
    op_i  = iss_cnt[1:0];
    op_j  = iss_cnt[3:2];
    b_row = (op_i == 2'd3) ? {FP_ONE, FP_ZERO, FP_ZERO, FP_ZERO} : {FP_ZERO, basis[op_i]};
    t_col = '0;
    t_col[op_j] = FP_ONE;
    if (op_j == 2'd3) t_col = {FP_ONE, fp_neg(pos[2]), fp_neg(pos[1]), fp_neg(pos[0])};
    op_a = (state == ST_VIEW) ? b_row : proj[sel][op_i];
    op_b = (state == ST_VIEW) ? t_col : v_m[op_j];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= ST_IDLE;
      iss_cnt         <= '0;
      col_cnt         <= '0;
      out_idx         <= '0;
      proj_wr_err_out <= 1'b0;
      basis           <= '0;
      pos             <= '0;
      sel             <= '0;
      skip            <= 1'b0;
      v_m             <= '0;
      r_m             <= '0;
      for (int s = 0; s < NUM_PROJ; s++) proj[s] <= proj_reset(s);
    end else begin
      state           <= state_nx;
      proj_wr_err_out <= proj_wr_en_in && !wr_ok;
      if (wr_ok) proj[proj_wr_slot_in][proj_wr_row_in] <= proj_wr_data_in;
      if (accept) begin
        basis <= {direction_in, up_in, right_in};
        pos   <= pos_in;
        sel   <= proj_sel_in;
        skip  <= skip_proj_in || int'(proj_sel_in) >= NUM_PROJ;
      end
      if (dot_v_in) iss_cnt <= iss_cnt + 5'd1;
      if (collect) begin
        col_cnt <= col_cnt + 4'd1;
        if (state == ST_VIEW) v_m[col_cnt[3:2]][col_cnt[1:0]] <= dot_c;
        else r_m[col_cnt[3:2]][col_cnt[1:0]] <= dot_c;
      end
      if (last) iss_cnt <= '0;
      if (valid_out && ready_in) out_idx <= out_idx + 2'd1;
    end
  end

  fp32_dot u_dot (
    .clk      (clk_in),
    .rst      (~rst_n_in),
    .valid_in (dot_v_in),
    .a_in     (op_a),
    .b_in     (op_b),
    .valid_out(dot_v),
    .c_out    (dot_c)
  );
endmodule

// File: tb/tb_camera_matrix_gen.sv
// tb_camera_matrix_gen: real-valued matrix model with per-column scoreboard plus literal column checks
module tb_camera_matrix_gen;
  localparam int NP = 3;
  localparam logic [31:0] ZERO = 32'h0, ONE = 32'h3F800000, TWO = 32'h40000000, NTWO = 32'hC0000000;
  localparam logic [31:0] THREE = 32'h40400000, NTHREE = 32'hC0400000, NONE = 32'hBF800000;
  localparam logic [31:0] ONEP5 = 32'h3FC00000, QTR = 32'h3E800000;
  localparam logic [2:0][31:0] EX = {ZERO, ZERO, ONE};
  localparam logic [2:0][31:0] EY = {ZERO, ONE, ZERO};
  localparam logic [2:0][31:0] EZ = {ONE, ZERO, ZERO};
  localparam logic [2:0][31:0] NEZ = {NONE, ZERO, ZERO};
  localparam logic [2:0][31:0] P0 = {ZERO, ZERO, ZERO};
  localparam logic [2:0][31:0] PX2 = {ZERO, ZERO, TWO};
  localparam logic [2:0][31:0] PG = {QTR, NTHREE, ONEP5};

  logic clk_in = 1'b0, rst_n_in = 1'b0, valid_in = 1'b0, ready_out, skip_proj_in = 1'b0;
  logic [2:0][31:0] right_in = '0, up_in = '0, direction_in = '0, pos_in = '0;
  logic [1:0] proj_sel_in = '0, proj_wr_slot_in = '0, proj_wr_row_in = '0, col_idx_out;
  logic proj_wr_en_in = 1'b0, proj_wr_err_out, valid_out, ready_in = 1'b1;
  logic [3:0][31:0] proj_wr_data_in = '0, col_out, held;

  typedef struct {real v[4]; int idx;} col_t;
  col_t exp_q[$];
  col_t ce;
  logic [31:0] mp [NP][4][4];
  logic [31:0] got [4][4];
  int n_cmp = 0, n_fail = 0;
  logic bad_c;

  camera_matrix_gen #(.NUM_PROJ(NP), .SLOT_W(2)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .valid_in(valid_in), .ready_out(ready_out),
    .right_in(right_in), .up_in(up_in), .direction_in(direction_in), .pos_in(pos_in),
    .proj_sel_in(proj_sel_in), .skip_proj_in(skip_proj_in), .proj_wr_en_in(proj_wr_en_in),
    .proj_wr_slot_in(proj_wr_slot_in), .proj_wr_row_in(proj_wr_row_in),
    .proj_wr_data_in(proj_wr_data_in), .proj_wr_err_out(proj_wr_err_out),
    .valid_out(valid_out), .ready_in(ready_in), .col_out(col_out), .col_idx_out(col_idx_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic real fp2r(input logic [31:0] b);
    real m;
    int e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic close(input real a, input real b);
    real d, t;
    d = (a > b) ? a - b : b - a;
    t = (b < 0.0) ? -b : b;
    return d <= 1.0e-5 * (1.0 + t);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NP; s++)
      for (int i = 0; i < 4; i++)
        for (int k = 0; k < 4; k++) mp[s][i][k] = (i == k) ? ONE : ZERO;
    mp[0][0][0] = 32'h3F000000;
    mp[0][1][1] = 32'h3F2AAAAA;
    mp[0][2][2] = 32'hBE800000;
    mp[0][2][3] = 32'hBF800000;
  endtask

  // scoreboard: every accepted column must match the next model column
  always @(negedge clk_in) begin
    if (rst_n_in && valid_out && ready_in) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL col_unexpected idx=%0d got=%h", col_idx_out, col_out);
      end else begin
        ce = exp_q.pop_front();
        bad_c = (int'(col_idx_out) != ce.idx);
        for (int i = 0; i < 4; i++) begin
          got[col_idx_out][i] = col_out[i];
          if (!close(fp2r(col_out[i]), ce.v[i])) bad_c = 1'b1;
        end
        if (bad_c) begin
          n_fail++;
          $display("FAIL col%0d got idx=%0d %h expected idx=%0d %f %f %f %f", ce.idx, col_idx_out,
                   col_out, ce.idx, ce.v[0], ce.v[1], ce.v[2], ce.v[3]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] g, input logic [127:0] e);
    n_cmp++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, g, e);
    end
  endtask

  task automatic chk_col(input string nm, input int j, input logic [31:0] e0, e1, e2, e3);
    logic [31:0] ev [4];
    logic bad;
    ev = '{e0, e1, e2, e3};
    bad = 1'b0;
    n_cmp++;
    for (int i = 0; i < 4; i++) if (fp2r(got[j][i]) != fp2r(ev[i])) bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL %s col%0d got=%h %h %h %h expected=%h %h %h %h", nm, j, got[j][0], got[j][1],
               got[j][2], got[j][3], e0, e1, e2, e3);
    end
  endtask

  task automatic request(input logic [2:0][31:0] r, u, d, p, input logic [1:0] sel, input logic sk);
    real b [4][4], tm [4][4], v [4][4], pm [4][4], res [4][4];
    logic [2:0][31:0] bs [3];
    col_t c;
    logic usep;
    int t;
    t = 0;
    while (!ready_out && t < 200) begin @(posedge clk_in); #1; t++; end
    if (!ready_out) begin
      n_cmp++; n_fail++;
      $display("FAIL req_timeout ready_out=%b required=1", ready_out);
      return;
    end
    right_in = r; up_in = u; direction_in = d; pos_in = p;
    proj_sel_in = sel; skip_proj_in = sk; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    bs[0] = r; bs[1] = u; bs[2] = d;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        b[i][k] = (i == 3 && k == 3) ? 1.0 : 0.0;
        if (i < 3 && k < 3) b[i][k] = fp2r(bs[i][k]);
        tm[i][k] = (i == k) ? 1.0 : 0.0;
      end
    for (int k = 0; k < 3; k++) tm[k][3] = -fp2r(p[k]);
    usep = !sk && int'(sel) < NP;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        v[i][j] = 0.0;
        for (int k = 0; k < 4; k++) v[i][j] += b[i][k] * tm[k][j];
        pm[i][j] = usep ? fp2r(mp[sel][i][j]) : 0.0;
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        res[i][j] = 0.0;
        for (int k = 0; k < 4; k++) res[i][j] += pm[i][k] * v[k][j];
        if (!usep) res[i][j] = v[i][j];
      end
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) c.v[i] = res[i][j];
      c.idx = j;
      exp_q.push_back(c);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || valid_out) && t < 300) begin @(posedge clk_in); #1; t++; end
    n_cmp++;
    if (exp_q.size() != 0 || valid_out || !ready_out) begin
      n_fail++;
      $display("FAIL drain pending=%0d valid_out=%b ready_out=%b required 0/0/1", exp_q.size(),
               valid_out, ready_out);
    end
  endtask

  task automatic pwrite(input logic [1:0] slot, input logic [1:0] row, input logic [3:0][31:0] data,
                        input logic ok);
    proj_wr_en_in = 1'b1; proj_wr_slot_in = slot; proj_wr_row_in = row; proj_wr_data_in = data;
    @(posedge clk_in); #1;
    proj_wr_en_in = 1'b0;
    chk("wr_err", 128'(proj_wr_err_out), 128'(!ok));
    if (ok) for (int k = 0; k < 4; k++) mp[slot][row][k] = data[k];
    else begin
      @(posedge clk_in); #1;
      chk("wr_err_pulse_end", 128'(proj_wr_err_out), 128'(0));
    end
  endtask

  initial begin
    int t;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rst_ready", 128'(ready_out), 128'(1));
    chk("rst_valid", 128'(valid_out), 128'(0));
    chk("rst_col", 128'(col_out), 128'(0));
    chk("rst_idx", 128'(col_idx_out), 128'(0));
    chk("rst_err", 128'(proj_wr_err_out), 128'(0));

    request(EX, EY, EZ, P0, 2'd0, 1'b1);
    drain();
    chk_col("ident", 0, ONE, ZERO, ZERO, ZERO);
    chk_col("ident", 1, ZERO, ONE, ZERO, ZERO);
    chk_col("ident", 2, ZERO, ZERO, ONE, ZERO);
    chk_col("ident", 3, ZERO, ZERO, ZERO, ONE);

    request(EX, EY, EZ, PX2, 2'd0, 1'b1);
    drain();
    chk_col("translate", 3, NTWO, ZERO, ZERO, ONE);

    request(EX, EY, EZ, P0, 2'd0, 1'b0);
    drain();
    chk_col("ortho", 0, 32'h3F000000, ZERO, ZERO, ZERO);
    chk_col("ortho", 1, ZERO, 32'h3F2AAAAA, ZERO, ZERO);
    chk_col("ortho", 2, ZERO, ZERO, 32'hBE800000, ZERO);
    chk_col("ortho", 3, ZERO, ZERO, 32'hBF800000, ONE);

    pwrite(2'd2, 2'd0, {ZERO, ZERO, ZERO, TWO}, 1'b1);
    request(EX, EY, EZ, P0, 2'd2, 1'b0);
    drain();
    chk_col("slot2_write", 0, TWO, ZERO, ZERO, ZERO);
    request(EX, EY, EZ, P0, 2'd2, 1'b0);
    repeat (3) @(posedge clk_in);
    #1 pwrite(2'd2, 2'd0, {ZERO, ZERO, ZERO, THREE}, 1'b0);
    drain();
    request(EX, EY, EZ, P0, 2'd2, 1'b0);
    drain();
    chk_col("slot2_kept", 0, TWO, ZERO, ZERO, ZERO);

    pwrite(2'd3, 2'd0, {ZERO, ZERO, ZERO, THREE}, 1'b0);
    request(EX, EY, EZ, PX2, 2'd3, 1'b0);
    drain();
    chk_col("bad_sel_view", 3, NTWO, ZERO, ZERO, ONE);

    request(EY, NEZ, EX, PG, 2'd0, 1'b0);
    drain();
    request(EY, NEZ, EX, PG, 2'd2, 1'b0);
    drain();

    // column 1 held back for 5 cycles
    ready_in = 1'b0;
    request(EY, NEZ, EX, PG, 2'd1, 1'b0);
    t = 0;
    while (!valid_out && t < 200) begin @(posedge clk_in); #1; t++; end
    chk("stall_valid", 128'(valid_out), 128'(1));
    ready_in = 1'b1;
    @(posedge clk_in); #1;
    ready_in = 1'b0;
    held = col_out;
    chk("stall_idx", 128'(col_idx_out), 128'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      chk("stall_hold", {valid_out, 2'(col_idx_out), col_out}, {1'b1, 2'd1, held});
    end
    @(posedge clk_in); #1;
    ready_in = 1'b1;
    drain();

    request(EY, NEZ, EX, PG, 2'd0, 1'b0);
    repeat (24) @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    #1;
    chk("midrun_rst_valid", 128'(valid_out), 128'(0));
    chk("midrun_rst_idx", 128'(col_idx_out), 128'(0));
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    chk("post_rst_ready", 128'(ready_out), 128'(1));
    request(EY, NEZ, EX, PG, 2'd0, 1'b0);
    drain();
    request(EX, EY, EZ, P0, 2'd2, 1'b0);
    drain();
    chk_col("slot2_reset", 0, ONE, ZERO, ZERO, ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/camera_matrix_gen.md
CAMERA_MATRIX_GEN -- requirements
Module: camera_matrix_gen

Interface
REQ-001 Parameter NUM_PROJ, default 4: number of writable projection-matrix slots (>=2).
REQ-002 Parameter SLOT_W, default $clog2(NUM_PROJ): slot index width.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk_in  in  1  sole clock.
REQ-005 rst_n_in  in  1  async active-low reset.
REQ-006 valid_in / ready_out  in / out  1 / 1  camera request handshake.
REQ-007 right_in, up_in, direction_in, pos_in  in  [2:0][31:0] each  FP32 camera basis and position; element 0 is x.
REQ-008 proj_sel_in  in  SLOT_W  projection slot used by the request.
REQ-009 skip_proj_in  in  1  1 = output the view matrix only.
REQ-010 proj_wr_en_in, proj_wr_slot_in, proj_wr_row_in, proj_wr_data_in  in  1, SLOT_W, 2, [3:0][31:0]  projection row write port.
REQ-011 proj_wr_err_out  out  1  one-cycle pulse when a write is rejected.
REQ-012 valid_out / ready_in  out / in  1 / 1  result column handshake.
REQ-013 col_out  out  [3:0][31:0]  result column, element 0 is row 0.
REQ-014 col_idx_out  out  2  index of the column on col_out.

Function
REQ-015 States: Idle, ViewRun, ProjRun, Output.
REQ-016 ready_out shall be 1 only in Idle; a request is accepted when valid_in && ready_out, and all inputs are latched in that cycle.
REQ-017 View product V = B*T. B rows are {0,right}, {0,up}, {0,direction} and {1,0,0,0}. T is the identity with column 3 = {-pos.x, -pos.y, -pos.z, 1}. Negation is a sign-bit flip.
REQ-018 Result R = P[slot]*V, or R = V when skip_proj_in is latched 1; in that case ProjRun is skipped and ViewRun goes directly to Output.
REQ-019 Each Run state issues 16 dot products, one per cycle, column-major: j outer, i inner; element (i,j) = row i of A dot column j of B.
REQ-020 Results shall be collected on dot_valid_out in issue order, concurrently with issuing; the block shall make no assumption about dot latency beyond in-order return.
REQ-021 View results go to a V register separate from the operands; projection results go to a separate R register. No in-place overwrite.
REQ-022 A Run state exits when the 16th result is collected, never on issue completion alone.
REQ-023 Output presents columns 0..3 in order. valid_out is held with col_out and col_idx_out stable until ready_in. The column advances on handshake. After column 3 is accepted the block returns to Idle with valid_out=0 on the next cycle.
REQ-024 Projection writes are accepted only in Idle; a write in the same cycle as an accepted request is applied first.
REQ-025 A write outside Idle, or with proj_wr_slot_in >= NUM_PROJ, is ignored and pulses proj_wr_err_out for one cycle.
REQ-026 A latched proj_sel_in >= NUM_PROJ shall be treated as skip_proj=1.
REQ-027 dot_valid_out while in Idle or Output shall be ignored.

Reset
REQ-028 On rst_n_in low: state=Idle, all counters 0, valid_out=0, col_out=0, col_idx_out=0, proj_wr_err_out=0, ready_out=1 after release. This applies mid-operation.
REQ-029 Slot 0 resets to the orthographic matrix: row0 x=0x3F000000; row1 y=0x3F2AAAAA; row2 z=0xBE800000, w=0xBF800000; row3 w=0x3F800000; all other elements 0.
REQ-030 All other slots reset to identity.
REQ-031 fp32_dot reset shall be driven by ~rst_n_in so that in-flight results are discarded.

Structure
REQ-032 A shared graphics package shall hold FP32 constants (0, 1.0, ortho values), the mat4 row/column typedef and the state enum.
REQ-033 The block shall use exactly one fp32_dot instance (valid_in, a_in, b_in -> valid_out, c_out); there are no other sub-modules.

Verification
REQ-034 right=(1,0,0), up=(0,1,0), dir=(0,0,1), pos=0, skip_proj=1 -> four columns forming the identity; col0={0,0,0,0x3F800000}, element 0 last.
REQ-035 Same basis, pos=(2.0,0,0), skip_proj=1 -> col3 elements (0xC0000000, 0, 0, 0x3F800000).
REQ-036 Identity camera, pos=0, slot 0 after reset -> col0 (0x3F000000,0,0,0); col1 (0,0x3F2AAAAA,0,0); col2 (0,0,0xBE800000,0); col3 (0,0,0xBF800000,0x3F800000).
REQ-037 Write slot 2 row 0 = (2.0,0,0,0) in Idle, then request identity camera with sel=2 -> col0 (0x40000000,0,0,0). The same write issued during ViewRun -> proj_wr_err_out pulses and slot 2 is unchanged.
REQ-038 ready_in held 0 for 5 cycles on col1 -> col_out and col_idx_out=1 stable throughout; no column is lost or duplicated.
REQ-039 rst_n_in pulsed low mid-ProjRun -> valid_out=0 immediately; the next request yields the correct result with no stale dot results.
